// File: rtl/async_fifo_pkg.sv
// Shared async FIFO helpers: Gray/binary conversion and depth from address width.
// Used by both the write-side and read-side pointer blocks.
package async_fifo_pkg;

  function automatic int fifo_depth(input int addrsize);
    return 1 << addrsize;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary decoder for a synchronised FIFO pointer.
module gray2bin #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  assign bin = WIDTH'(async_fifo_pkg::gray2bin(32'(gray)));

endmodule

// File: rtl/wptr_level.sv
// Async FIFO write-side pointer, exact fill level and almost-full/full flags with
// all-or-nothing multi-entry push. Overflow sticky flag built only with WPTR_LEVEL_OVF_EN.
module wptr_level
  import async_fifo_pkg::*;
#(
  parameter  int ADDRSIZE = 4,
  parameter  int PUSHMAX  = 1,
  localparam int CW       = $clog2(PUSHMAX + 1)
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic [CW-1:0]       wpush,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic [ADDRSIZE:0]   awfull_th,
  input  logic                wovf_clr,
  output logic                wacc,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic [ADDRSIZE:0]   wlevel,
  output logic                wfull,
  output logic                awfull,
  output logic                wovf
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(fifo_depth(ADDRSIZE));

  logic [PW-1:0] wbin;
  logic [PW-1:0] rbin;
  logic [PW-1:0] wbinnext;
  logic [PW-1:0] wlevel_next;
  logic [PW-1:0] free;
  logic [PW-1:0] push_ext;

  gray2bin #(.WIDTH(PW)) u_rptr_dec (
    .gray (wq2_rptr),
    .bin  (rbin)
  );

  assign push_ext = PW'(wpush);
  assign free     = DEPTH_P - wlevel;
  assign wacc     = (wpush != '0) && (push_ext <= free);
  assign waddr    = wbin[ADDRSIZE-1:0];

  // Modular subtraction keeps the level exact across pointer wrap.
  assign wbinnext    = wbin + (wacc ? push_ext : '0);
  assign wlevel_next = wbinnext - rbin;

  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin   <= '0;
      wptr   <= '0;
      wlevel <= '0;
      wfull  <= 1'b0;
      awfull <= 1'b0;
    end else begin
      wbin   <= wbinnext;
      wptr   <= PW'(bin2gray(32'(wbinnext)));
      wlevel <= wlevel_next;
      wfull  <= (wlevel_next == DEPTH_P);
      awfull <= ((DEPTH_P - wlevel_next) <= awfull_th);
    end
  end

`ifdef WPTR_LEVEL_OVF_EN
  // A rejected push in the same cycle as a clear keeps the flag set.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wovf <= 1'b0;
    end else if ((wpush != '0) && !wacc) begin
      wovf <= 1'b1;
    end else if (wovf_clr) begin
      wovf <= 1'b0;
    end
  end
`else
  logic unused_wovf_clr;
  assign unused_wovf_clr = wovf_clr;
  assign wovf = 1'b0;
`endif

endmodule
